// File: rtl/full_adder_2bit_pkg.sv
// Shared types for the 2-bit-result full adder: the packed {c_out, s} result
// word and a helper that assembles it from the individual bits.
package full_adder_2bit_pkg;

  typedef struct packed {
    logic c_out;
    logic s;
  } fa_result_t;

  function automatic fa_result_t fa_pack(input logic s, input logic c_out);
    fa_result_t r;
    r.s     = s;
    r.c_out = c_out;
    return r;
  endfunction

endpackage

// File: rtl/full_adder_2bit_if.sv
// Operand/result bundle for full_adder_2bit; master drives operands and
// in_valid, slave returns sum, carry and out_valid.
interface full_adder_2bit_if;
  import full_adder_2bit_pkg::*;

  logic a;
  logic b;
  logic c_in;
  logic in_valid;
  logic s;
  logic c_out;
  logic out_valid;

  modport master (
    output a, b, c_in, in_valid,
    input  s, c_out, out_valid
  );

  modport slave (
    input  a, b, c_in, in_valid,
    output s, c_out, out_valid
  );

endinterface

// File: rtl/full_adder_2bit_cell.sv
// Pure combinational one-bit full adder: sum is the three-way parity,
// carry is the majority of the three inputs.
module full_adder_cell
  import full_adder_2bit_pkg::*;
(
  input  logic a,
  input  logic b,
  input  logic c_in,
  output logic s,
  output logic c_out
);

  assign s     = a ^ b ^ c_in;
  assign c_out = (a & b) | (a & c_in) | (b & c_in);

endmodule

// File: rtl/full_adder_2bit.sv
// Full adder producing {c_out, s} = a + b + c_in, with an optional single
// output register stage selected by REGISTERED.
module full_adder_2bit
  import full_adder_2bit_pkg::*;
#(
  parameter bit REGISTERED = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  full_adder_2bit_if.slave     bus
);

  logic       s_p0;
  logic       c_out_p0;
  fa_result_t sum_p0;

  full_adder_cell u_cell (
    .a     (bus.a),
    .b     (bus.b),
    .c_in  (bus.c_in),
    .s     (s_p0),
    .c_out (c_out_p0)
  );

  assign sum_p0 = fa_pack(s_p0, c_out_p0);

  generate
    if (REGISTERED) begin : g_reg
      fa_result_t sum_p1;
      logic       vld_p1;

      // p0 -> p1: result only captured on valid so X operands cannot leak in
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          sum_p1 <= '0;
          vld_p1 <= 1'b0;
        end else begin
          vld_p1 <= bus.in_valid;
          if (bus.in_valid) begin
            sum_p1 <= sum_p0;
          end
        end
      end

      assign bus.s         = sum_p1.s;
      assign bus.c_out     = sum_p1.c_out;
      assign bus.out_valid = vld_p1;
    end else begin : g_comb
      logic unused_clk_rst;
      assign unused_clk_rst = &{1'b0, clk, rst_n};

      assign bus.s         = sum_p0.s;
      assign bus.c_out     = sum_p0.c_out;
      assign bus.out_valid = bus.in_valid;
    end
  endgenerate

endmodule

// File: tb/tb_full_adder_2bit.sv
// Directed scoreboard bench for full_adder_2bit: registered instance checked
// one cycle after drive, combinational instance checked in the same cycle.
module tb_full_adder_2bit;
  import full_adder_2bit_pkg::*;

  typedef struct packed {
    logic v;
    logic s;
    logic c;
  } exp_t;

  logic clk;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;
  exp_t q[$];
  logic m_s;
  logic m_c;

  full_adder_2bit_if bus ();
  full_adder_2bit_if bus_c ();

  full_adder_2bit #(.REGISTERED(1'b1)) u_dut_reg (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  full_adder_2bit #(.REGISTERED(1'b0)) u_dut_comb (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input logic obs, input logic expv, input string tag);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, expv);
    end
  endtask

  task automatic pop_check();
    exp_t e;
    if (q.size() == 0) begin
      total++;
      bad++;
      $error("FAIL scoreboard_empty observed=0 entries expected=1 entry");
    end else begin
      e = q.pop_front();
      chk(bus.out_valid, e.v, "out_valid");
      chk(bus.s,         e.s, "s");
      chk(bus.c_out,     e.c, "c_out");
    end
  endtask

  task automatic step(input logic v, input logic ia, input logic ib, input logic ic);
    logic [1:0] sum;
    sum = 2'b00;
    @(negedge clk);
    bus.in_valid   = v;  bus.a   = ia; bus.b   = ib; bus.c_in   = ic;
    bus_c.in_valid = v;  bus_c.a = ia; bus_c.b = ib; bus_c.c_in = ic;
    if (v === 1'b1) begin
      sum = 2'(ia) + 2'(ib) + 2'(ic);
      m_s = sum[0];
      m_c = sum[1];
    end
    q.push_back({v, m_s, m_c});
    #1;
    chk(bus_c.out_valid, v, "comb_out_valid");
    if (v === 1'b1) begin
      chk(bus_c.s,     sum[0], "comb_s");
      chk(bus_c.c_out, sum[1], "comb_c_out");
    end
    @(posedge clk);
    #1;
    pop_check();
  endtask

  initial begin
    rst_n = 1'b1;
    bus.in_valid = 1'b0; bus.a = 1'b0; bus.b = 1'b0; bus.c_in = 1'b0;
    bus_c.in_valid = 1'b1; bus_c.a = 1'b1; bus_c.b = 1'b1; bus_c.c_in = 1'b1;
    m_s = 1'b0;
    m_c = 1'b0;

    // Reset state before any clock edge; combinational instance ignores reset
    #1 rst_n = 1'b0;
    #1;
    chk(bus.s,           1'b0, "rst_s");
    chk(bus.c_out,       1'b0, "rst_c_out");
    chk(bus.out_valid,   1'b0, "rst_out_valid");
    chk(bus_c.s,         1'b1, "comb_rst_s");
    chk(bus_c.c_out,     1'b1, "comb_rst_c_out");
    @(negedge clk);
    rst_n = 1'b1;

    // All eight operand combinations, back to back
    for (int i = 0; i < 8; i++) begin
      step(1'b1, i[2], i[1], i[0]);
    end

    // Hold on invalid cycles, including unknown operands
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b1);
    step(1'b0, 1'bx, 1'bx, 1'bx);

    // Consecutive valid inputs
    step(1'b1, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0);

    // Asynchronous reset clears s=1,c_out=1 without a clock edge
    step(1'b1, 1'b1, 1'b1, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk(bus.s,         1'b0, "async_rst_s");
    chk(bus.c_out,     1'b0, "async_rst_c_out");
    chk(bus.out_valid, 1'b0, "async_rst_out_valid");
    q.delete();
    m_s = 1'b0;
    m_c = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // Mid-stream reset discards the in-flight input
    step(1'b1, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    bus.in_valid = 1'b1; bus.a = 1'b1; bus.b = 1'b1; bus.c_in = 1'b0;
    #2 rst_n = 1'b0;
    q.delete();
    m_s = 1'b0;
    m_c = 1'b0;
    q.push_back({1'b0, 1'b0, 1'b0});
    @(posedge clk);
    #1;
    pop_check();
    @(negedge clk);
    rst_n = 1'b1;
    bus.in_valid = 1'b0;
    step(1'b1, 1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
